// File: rtl/myram_arbiter_pkg.sv
// myram_arb_pkg: shared widths, FSM states and read-tag type for the RAM arbiter
package myram_arb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // One in-flight read: whether the slot holds a read, and which port gets the data
    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/myram_arbiter_if.sv
// myram_arbiter_if: requester, sweep-control and RAM command bus of the arbiter
interface myram_arbiter_if;
    import myram_arb_pkg::*;

    logic              clear_req;
    logic              busy;
    logic              clear_done;

    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_address;
    logic [DATA_W-1:0] p0_data;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_q;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_address;
    logic [DATA_W-1:0] p1_data;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_q;

    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

    // The arbiter itself
    modport slave (
        input  clear_req,
        output busy, clear_done,
        input  p0_req, p0_we, p0_address, p0_data,
        output p0_gnt, p0_rvalid, p0_q,
        input  p1_req, p1_we, p1_address, p1_data,
        output p1_gnt, p1_rvalid, p1_q,
        output ram_data, ram_address, ram_we,
        input  ram_q
    );

    // Requesters plus the RAM, seen from outside the arbiter
    modport master (
        output clear_req,
        input  busy, clear_done,
        output p0_req, p0_we, p0_address, p0_data,
        input  p0_gnt, p0_rvalid, p0_q,
        output p1_req, p1_we, p1_address, p1_data,
        input  p1_gnt, p1_rvalid, p1_q,
        input  ram_data, ram_address, ram_we,
        output ram_q
    );

endinterface

// File: rtl/myram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; a tie goes to the port that did not win last
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_en,
    input  logic       i_accept,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // 1 = port 1 won the most recent accepted transfer; starts at 1 so port 0 wins the first tie
    logic r_last;

    // Lone requester wins outright; on a tie the port that lost last time goes first
    always_comb begin
        o_gnt[0] = i_en && i_req[0] && (!i_req[1] || r_last);
        o_gnt[1] = i_en && i_req[1] && (!i_req[0] || !r_last);
    end

    // Only an accepted transfer moves the round-robin pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_last <= 1'b1;
        else if (i_accept)
            r_last <= o_gnt[1];
    end

endmodule

// File: rtl/myram_arbiter.sv
// myram_arbiter: two-port round-robin front end for a single-port registered RAM, with zero sweep
module myram_arbiter
    import myram_arb_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    myram_arbiter_if.slave bus
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_cnt;
    logic                  w_arb_en;
    logic                  w_sweep_end;

    logic [1:0]            w_gnt;
    logic                  w_accept;
    logic                  w_win;
    logic                  w_win_we;
    logic [ADDR_W-1:0]     w_win_addr;
    logic [DATA_W-1:0]     w_win_data;

    logic                  r_ram_we;
    logic [ADDR_W-1:0]     r_ram_address;
    logic [DATA_W-1:0]     r_ram_data;

    rd_tag_t               w_tag_in;
    rd_tag_t               w_tag_out;
    rd_tag_t [RD_LATENCY:0] r_tag;

    logic [1:0]            r_rvalid;
    logic [DATA_W-1:0]     r_q0;
    logic [DATA_W-1:0]     r_q1;
    logic                  r_clear_done;

    rr_arb2 u_arb (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_en     (w_arb_en),
        .i_accept (w_accept),
        .i_req    ({bus.p1_req, bus.p0_req}),
        .o_gnt    (w_gnt)
    );

    // Sweep ends on the cycle the last address is issued; clear_req in RUN blocks grants that cycle
    always_comb begin
        w_state_nxt = r_state;
        w_arb_en    = 1'b0;
        w_sweep_end = 1'b0;
        case (r_state)
            CLEAR: begin
                w_sweep_end = &r_cnt;
                if (w_sweep_end)
                    w_state_nxt = RUN;
            end
            RUN: begin
                w_arb_en = !bus.clear_req;
                if (bus.clear_req)
                    w_state_nxt = CLEAR;
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    // State register; reset lands in CLEAR so the RAM is zeroed after power-up
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= CLEAR;
        else
            r_state <= w_state_nxt;
    end

    // Sweep address counter; wraps to 0 at the end of a sweep and is parked at 0 in RUN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else
            r_cnt <= (r_state == CLEAR) ? r_cnt + 1'b1 : '0;
    end

    // Select the granted port's command; gnt already implies req
    always_comb begin
        w_accept   = |w_gnt;
        w_win      = w_gnt[1];
        w_win_we   = w_win ? bus.p1_we      : bus.p0_we;
        w_win_addr = w_win ? bus.p1_address : bus.p0_address;
        w_win_data = w_win ? bus.p1_data    : bus.p0_data;
        w_tag_in   = '{valid: w_accept && !w_win_we, port: w_win};
        w_tag_out  = r_tag[RD_LATENCY];
    end

    // RAM command register: sweep writes in CLEAR, the winner on an accept, otherwise idle with address/data held
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_we      <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
        end else if (r_state == CLEAR) begin
            r_ram_we      <= 1'b1;
            r_ram_address <= r_cnt;
            r_ram_data    <= '0;
        end else if (w_accept) begin
            r_ram_we      <= w_win_we;
            r_ram_address <= w_win_addr;
            r_ram_data    <= w_win_we ? w_win_data : '0;
        end else begin
            r_ram_we      <= 1'b0;
        end
    end

    // Read tags follow the command through the RAM's input and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_tag <= '0;
        else
            r_tag <= {r_tag[RD_LATENCY-1:0], w_tag_in};
    end

    // Steer returning RAM data to its port; q holds between reads
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid <= '0;
            r_q0     <= '0;
            r_q1     <= '0;
        end else begin
            r_rvalid[0] <= w_tag_out.valid && !w_tag_out.port;
            r_rvalid[1] <= w_tag_out.valid &&  w_tag_out.port;
            if (w_tag_out.valid && !w_tag_out.port)
                r_q0 <= bus.ram_q;
            if (w_tag_out.valid && w_tag_out.port)
                r_q1 <= bus.ram_q;
        end
    end

    // One-cycle completion pulse, aligned with busy dropping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_clear_done <= 1'b0;
        else
            r_clear_done <= w_sweep_end;
    end

    assign bus.busy        = (r_state == CLEAR);
    assign bus.clear_done  = r_clear_done;
    assign bus.p0_gnt      = w_gnt[0];
    assign bus.p1_gnt      = w_gnt[1];
    assign bus.p0_rvalid   = r_rvalid[0];
    assign bus.p1_rvalid   = r_rvalid[1];
    assign bus.p0_q        = r_q0;
    assign bus.p1_q        = r_q1;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_address = r_ram_address;
    assign bus.ram_data    = r_ram_data;

endmodule

// File: tb/tb_myram_arbiter.sv
// tb_myram_arbiter: vector table plus read scoreboard against a registered single-port RAM model
module tb_myram_arbiter;
    import myram_arb_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    myram_arbiter_if bus ();

    myram_arbiter #(.RD_LATENCY(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // RAM: registered address/data/we on inclock, registered q on outclock
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] ram_a_r;
    always @(posedge clock) begin
        if (bus.ram_we)
            mem[bus.ram_address] <= bus.ram_data;
        ram_a_r   <= bus.ram_address;
        bus.ram_q <= mem[ram_a_r];
    end

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int rv_seen = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic              port;
        logic [DATA_W-1:0] q;
        int                cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic              port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_q;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic take(input logic p, input logic [DATA_W-1:0] q);
        exp_t e;
        rv_seen++;
        chk("rvalid_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rv_port", 32'(p), 32'(e.port));
            chk("rv_q", 32'(q), 32'(e.q));
            chk("rv_latency", cyc, e.cyc + 3);
        end
    endtask

    // Output monitor: grant invariants every cycle, read returns against the scoreboard
    always @(negedge clock) begin
        chk("gnt_exclusive", 32'(bus.p0_gnt & bus.p1_gnt), 0);
        chk("gnt_while_busy", 32'(bus.busy & (bus.p0_gnt | bus.p1_gnt)), 0);
        if (bus.p0_rvalid) take(1'b0, bus.p0_q);
        if (bus.p1_rvalid) take(1'b1, bus.p1_q);
    end

    task automatic set_req(input logic p, input logic r, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (p) begin
            bus.p1_req = r; bus.p1_we = we; bus.p1_address = a; bus.p1_data = d;
        end else begin
            bus.p0_req = r; bus.p0_we = we; bus.p0_address = a; bus.p0_data = d;
        end
    endtask

    // Request, wait for the grant, then record the expected read return
    task automatic access(input logic p, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] eq);
        int n = 0;
        set_req(p, 1'b1, we, a, d);
        @(negedge clock);
        while (!(p ? bus.p1_gnt : bus.p0_gnt) && n < 200) begin
            n++;
            @(negedge clock);
        end
        chk("gnt_wait", 32'(n < 200), 1);
        @(posedge clock);
        #1;
        if (!we) sb.push_back('{p, eq, cyc});
        set_req(p, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int rv0;
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 16'hDEAD;
        vt[0] = '{1'b0, 1'b1, 6'd5,  16'hBEEF, 16'h0000};
        vt[1] = '{1'b0, 1'b0, 6'd5,  16'h0000, 16'hBEEF};
        vt[2] = '{1'b1, 1'b0, 6'd5,  16'h0000, 16'hBEEF};
        vt[3] = '{1'b0, 1'b1, 6'd0,  16'h1234, 16'h0000};
        vt[4] = '{1'b1, 1'b1, 6'd63, 16'hFFFF, 16'h0000};
        vt[5] = '{1'b0, 1'b0, 6'd63, 16'h0000, 16'hFFFF};
        vt[6] = '{1'b1, 1'b0, 6'd0,  16'h0000, 16'h1234};
        vt[7] = '{1'b0, 1'b1, 6'd1,  16'h1111, 16'h0000};
        vt[8] = '{1'b1, 1'b1, 6'd2,  16'h2222, 16'h0000};
        bus.clear_req = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);

        // Reset values
        #1;
        chk("rst_busy", 32'(bus.busy), 1);
        chk("rst_ram_we", 32'(bus.ram_we), 0);
        chk("rst_done", 32'(bus.clear_done), 0);
        chk("rst_p0_q", 32'(bus.p0_q), 0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;

        // Power-up sweep: 64 zero writes, then one clear_done pulse
        for (int i = 0; i < 64; i++) begin
            @(posedge clock);
            #1;
            chk("sweep_we", 32'(bus.ram_we), 1);
            chk("sweep_addr", 32'(bus.ram_address), i);
            chk("sweep_data", 32'(bus.ram_data), 0);
            chk("sweep_busy", 32'(bus.busy), 32'(i < 63));
            chk("sweep_done", 32'(bus.clear_done), 32'(i == 63));
        end
        @(posedge clock);
        #1;
        chk("done_single", 32'(bus.clear_done), 0);
        chk("run_busy", 32'(bus.busy), 0);
        chk("run_idle_we", 32'(bus.ram_we), 0);

        // Vector table: single-port traffic, back-to-back
        for (int i = 0; i < 9; i++)
            access(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_q);

        // Both ports hold reads: alternate p0, p1, p0, p1
        set_req(1'b0, 1'b1, 1'b0, 6'd1, '0);
        set_req(1'b1, 1'b1, 1'b0, 6'd2, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("rr_gnt0", 32'(bus.p0_gnt), 32'(k % 2 == 0));
            chk("rr_gnt1", 32'(bus.p1_gnt), 32'(k % 2 == 1));
            @(posedge clock);
            #1;
            sb.push_back('{(k % 2 == 1), (k % 2 == 1) ? 16'h2222 : 16'h1111, cyc});
        end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (6) @(posedge clock);
        #1;

        // Clear sweep with reads in flight; a held request waits out the sweep
        access(1'b0, 1'b0, 6'd5, '0, 16'hBEEF);
        access(1'b1, 1'b0, 6'd1, '0, 16'h1111);
        bus.clear_req = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 6'd5, '0);
        @(negedge clock);
        chk("clr_no_gnt", 32'(bus.p0_gnt), 0);
        @(posedge clock);
        #1 bus.clear_req = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.p0_gnt && n < 200);
        chk("clr_gap", n, 65);
        chk("clr_done", 32'(bus.clear_done), 1);
        @(posedge clock);
        #1;
        sb.push_back('{1'b0, 16'h0000, cyc});
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (6) @(posedge clock);
        #1;

        // Reset one cycle after a read accept drops the read
        access(1'b0, 1'b1, 6'd7, 16'hABCD, '0);
        access(1'b0, 1'b0, 6'd7, '0, 16'hABCD);
        repeat (6) @(posedge clock);
        #1;
        access(1'b0, 1'b0, 6'd7, '0, 16'hABCD);
        set_req(1'b0, 1'b1, 1'b0, 6'd7, '0);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        sb.delete();
        rv0 = rv_seen;
        #1;
        chk("arst_busy", 32'(bus.busy), 1);
        chk("arst_gnt", 32'(bus.p0_gnt), 0);
        chk("arst_rvalid", 32'(bus.p0_rvalid), 0);
        chk("arst_p0_q", 32'(bus.p0_q), 0);
        chk("arst_ram_we", 32'(bus.ram_we), 0);
        chk("arst_ram_addr", 32'(bus.ram_address), 0);
        chk("arst_ram_data", 32'(bus.ram_data), 0);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("arst_dropped", rv_seen - rv0, 0);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/myram_arbiter.md
Name: myram_arbiter

Overview:
- Two-port round-robin controller that shares one single-port 64x16 LPM RAM (registered address/data/we, registered q) between two requesters.
- Accepts at most one access per cycle and drives the RAM command bus from registers.
- Tracks in-flight reads through a latency pipe and returns read data to the originating port.
- Sweeps the RAM to zero after reset and on request; the RAM's inclock and outclock are both tied to clock at the parent level.

Parameters:
- DATA_W, 16, RAM word width
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W
- RD_LATENCY, 2, edges from RAM command register to valid ram_q (inclock stage plus outclock stage)

Ports:
- clock  in  1  single clock for the block and the RAM
- reset_n  in  1  asynchronous, active-low reset
- clear_req  in  1  one-cycle pulse that requests a zero sweep
- busy  out  1  high while sweeping; no grants while high
- clear_done  out  1  one-cycle pulse at sweep completion
- p0_req, p1_req  in  1  access request
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_address, p1_address  in  ADDR_W  word address
- p0_data, p1_data  in  DATA_W  write data
- p0_gnt, p1_gnt  out  1  combinational accept; the transfer happens on the edge where req and gnt are both high
- p0_rvalid, p1_rvalid  out  1  read data valid, registered
- p0_q, p1_q  out  DATA_W  read data
- ram_data  out  DATA_W  to RAM data
- ram_address  out  ADDR_W  to RAM address
- ram_we  out  1  to RAM we
- ram_q  in  DATA_W  from RAM q

Behaviour:
- Reset (async, reset_n low):
  - state = CLEAR, clear counter = 0, last_grant = 1.
  - Read pipe flushed; in-flight reads are dropped and never return.
  - ram_we = 0, ram_address = 0, ram_data = 0.
  - All gnt, rvalid and clear_done = 0; p*_q = 0; busy = 1.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle registers ram_we = 1, ram_address = cnt, ram_data = 0, then cnt increments.
  - When cnt = 2**ADDR_W-1 has been issued, the FSM goes to RUN, busy drops, and clear_done pulses for 1 cycle.
  - A full sweep takes 64 cycles.
  - clear_req while in CLEAR is ignored.
  - RUN: clear_req → CLEAR with cnt = 0 on the next edge.
  - No grant is given in the cycle clear_req is sampled high.
  - Reads already in flight still complete with their rvalid.
- Arbitration (RUN only):
  - gnt is combinational from req, last_grant and state.
  - One request pending: grant it.
  - Both pending: grant the port that is not last_grant.
  - last_grant updates only on an accepted transfer.
  - After reset, port 0 wins the first tie.
  - gnt is never high for both ports, and never high while busy.
- Command issue:
  - On the accept edge, ram_we / ram_address / ram_data are loaded from the winning port.
  - For a read, ram_data = 0.
  - With no accept, ram_we = 0; address and data hold their values.
- Read return:
  - A tag {valid, port} shifts through a RD_LATENCY+1 stage pipe.
  - pN_rvalid is high, and pN_q = ram_q, exactly in the cycle after edge A+RD_LATENCY+1, where A is the accept edge. That is 3 cycles after accept for the default parameters.
  - pN_q holds its last value when rvalid is low.
- Ordering: commands issue in acceptance order to a single port.
  - A read accepted after a write to the same address returns the new data.
  - A read and a write accepted in the same cycle is impossible, since only one access is granted per cycle.
- Throughput: one access per cycle sustained; back-to-back reads give back-to-back rvalid.
- Address wrap: none; the address is used as-is.

Decomposition:
- Package myram_arb_pkg:
  - constants DATA_W and ADDR_W
  - state enum (CLEAR, RUN)
  - read-tag struct {valid, port}
- One sub-module, rr_arb2: two-way round-robin grant with a last_grant register, using req/accept inputs and gnt outputs.

Test Plan:
- Release reset, hold no requests → busy = 1 for 64 cycles; ram_we = 1 with ram_address 0..63 and ram_data = 0; then clear_done pulses once and busy = 0.
- p0 writes 0xBEEF to address 5, then p0 reads address 5 → p0_rvalid = 1 exactly 3 cycles after the read accept; p0_q = 0xBEEF; p1_rvalid stays 0.
- p0 and p1 both hold reads (addresses 1 and 2) for 4 cycles after reset → grants go p0, p1, p0, p1.
  - rvalid returns in the same order, with p0_q = mem[1] and p1_q = mem[2].
- Reads are in flight; pulse clear_req → no gnt for 64 cycles; the pending rvalids still arrive.
  - A subsequent read of address 5 returns 0x0000.
- reset_n asserted 1 cycle after a read accept → rvalid never asserts; outputs are at reset values immediately, without waiting for a clock edge.
